magnet_sequencer: RTL and testbench
===================================

MAGNET_SEQUENCER -- requirements
Module: magnet_sequencer

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- LATCH_TIMEOUT, 1000: cycles allowed in ENERGIZE for the object to be sensed.
- RELEASE_CYCLES, 500: cycles of reverse-drive demagnetise pulse; also the coil-off gap between retries.
- DEBOUNCE, 4: consecutive equal obj_near samples needed to accept a change.
- MAX_RETRY, 3: failed latch attempts before FAULT.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, input, 1: single clock; all logic on its rising edge.
- rst, input, 1: synchronous active-high reset.
- node_valid, input, 1: one-cycle pulse; the bot has reached node.
- node, input, 5: node index, qualified by node_valid.
- obj_near, input, 1: ultrasonic proximity; 1 means object at the magnet face.
- delatch, input, 1: drop request, level or pulse.
- fault_clr, input, 1: leave FAULT.
- o1, output, 1: coil forward drive.
- o2, output, 1: coil reverse drive.
- hold, output, 1: bot must stay stopped.
- carrying, output, 1: object latched.
- done, output, 1: one-cycle pulse on release complete.
- lost, output, 1: one-cycle pulse on object lost in CARRY.
- fault, output, 1: latch failed MAX_RETRY times.

Function
REQ-003 The FSM SHALL have states IDLE, ENERGIZE, RETRY_GAP, CARRY, RELEASE and FAULT. All outputs SHALL be registered and decoded from state.
REQ-004 IDLE SHALL drive o1=0, o2=0, hold=0. node_valid with node in PICK_NODES {10, 11, 22, 23} SHALL move to ENERGIZE next cycle, clearing the timer and retry count. Other nodes SHALL be ignored.
REQ-005 ENERGIZE SHALL drive o1=1, o2=0, hold=1.
- Filtered obj_near=1 SHALL move to CARRY.
- If the timer reaches LATCH_TIMEOUT-1 first, retry_cnt SHALL increment. The state SHALL go to FAULT when the incremented value equals MAX_RETRY, else to RETRY_GAP.
REQ-006 RETRY_GAP SHALL drive o1=0, o2=0, hold=1 for RELEASE_CYCLES, then return to ENERGIZE with the timer cleared.
REQ-007 CARRY SHALL drive o1=1, carrying=1, hold=0.
- delatch=1 SHALL move to RELEASE.
- Otherwise, filtered obj_near=0 SHALL pulse lost and move to IDLE.
REQ-008 RELEASE SHALL drive o1=0, o2=1, hold=1 for exactly RELEASE_CYCLES, then pulse done and enter IDLE.
REQ-009 FAULT SHALL drive o1=0, o2=0, hold=1, fault=1 until fault_clr=1, then go to IDLE.
REQ-010 o1 and o2 SHALL never both be 1 in any cycle. Every state change SHALL pass through at least one cycle with o1=o2=0 or go directly between opposite-drive-free states as listed.
REQ-011 The filter SHALL update its output only after DEBOUNCE consecutive identical samples. It SHALL restart counting on any mismatch.
REQ-012 Simultaneous events:
- delatch in ENERGIZE or RETRY_GAP SHALL abort to RELEASE; it has priority over timeout and over obj_near.
- delatch in IDLE or FAULT SHALL be ignored.
- node_valid outside IDLE SHALL be ignored.
- In CARRY, delatch SHALL win over a same-cycle loss, and no lost pulse SHALL occur.
REQ-013 Timers SHALL be wide enough for max(LATCH_TIMEOUT, RELEASE_CYCLES) with no wrap-around. retry_cnt SHALL saturate at MAX_RETRY.

Reset
REQ-014 On rst=1 at a clock edge, the block SHALL enter IDLE. All outputs, timers, retry_cnt and the filter state (to 0) SHALL clear. This SHALL override any state, including RELEASE mid-pulse.
REQ-015 After reset, the first node_valid SHALL be accepted on the first cycle after rst deasserts.

Structure
REQ-016 Package magnet_pkg SHALL hold the state enumeration, the PICK_NODES constants and the default parameter values.
REQ-017 The debounce SHALL be a sub-module, presence_filter (DEBOUNCE parameter, sample in, filtered out).

Verification
REQ-018 The bench SHALL cover these scenarios (stimulus -> required response):
- node_valid with node=22, obj_near rising 10 cycles later -> o1=1 one cycle after the pulse; carrying=1 and hold=0 DEBOUNCE cycles after the rise.
- In CARRY, delatch pulse -> o2=1 for exactly 500 cycles, then done pulses once and o1=o2=0.
- node=11 with obj_near held 0 -> three 1000-cycle energise windows with 500-cycle gaps, then fault=1; fault_clr -> IDLE.
- node=5 -> no output change. node_valid during CARRY -> ignored.
- obj_near glitch low for 3 cycles in CARRY -> no lost. Low for 4 cycles -> lost pulses, IDLE.
- rst asserted 200 cycles into RELEASE -> all outputs 0 next edge. o1&o2 is never 1 anywhere, checked by assertion.

Source files
------------

// File: rtl/magnet_pkg.sv
// Shared types and defaults for the magnet pick/release sequencer.
package magnet_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENERGIZE,
        ST_RETRY_GAP,
        ST_CARRY,
        ST_RELEASE,
        ST_FAULT
    } state_t;

    localparam int DEF_LATCH_TIMEOUT  = 1000;
    localparam int DEF_RELEASE_CYCLES = 500;
    localparam int DEF_DEBOUNCE       = 4;
    localparam int DEF_MAX_RETRY      = 3;

    localparam logic [4:0] PICK_NODE_0 = 5'd10;
    localparam logic [4:0] PICK_NODE_1 = 5'd11;
    localparam logic [4:0] PICK_NODE_2 = 5'd22;
    localparam logic [4:0] PICK_NODE_3 = 5'd23;

    typedef struct packed {
        logic o1;
        logic o2;
        logic hold;
        logic carrying;
        logic fault;
    } drive_t;

    function automatic logic is_pick_node(input logic [4:0] n);
        return (n == PICK_NODE_0) || (n == PICK_NODE_1) ||
               (n == PICK_NODE_2) || (n == PICK_NODE_3);
    endfunction

    function automatic logic is_timed(input state_t s);
        return (s == ST_ENERGIZE) || (s == ST_RETRY_GAP) || (s == ST_RELEASE);
    endfunction

    // Coil and status levels for each state; o1 and o2 are never set together.
    function automatic drive_t state_drive(input state_t s);
        drive_t d;
        d = '0;
        case (s)
            ST_ENERGIZE:  begin d.o1 = 1'b1; d.hold = 1'b1; end
            ST_RETRY_GAP: begin d.hold = 1'b1; end
            ST_CARRY:     begin d.o1 = 1'b1; d.carrying = 1'b1; end
            ST_RELEASE:   begin d.o2 = 1'b1; d.hold = 1'b1; end
            ST_FAULT:     begin d.hold = 1'b1; d.fault = 1'b1; end
            default:      d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/presence_filter.sv
// Debounce for the proximity sensor: a new level is accepted on the DEBOUNCE-th
// consecutive sample that differs from the current accepted level.
module presence_filter
    import magnet_pkg::*;
#(
    parameter int DEBOUNCE = DEF_DEBOUNCE
) (
    input  logic clk,
    input  logic rst,
    input  logic sample,
    output logic filtered
);

    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

    logic          stable;
    logic [CW-1:0] cnt;
    logic          accept;

    // The accepting sample itself counts, so the consumer sees the change on that edge.
    assign accept   = (sample != stable) && (cnt == CNT_LAST);
    assign filtered = accept ? sample : stable;

    always_ff @(posedge clk) begin
        if (rst) begin
            stable <= 1'b0;
            cnt    <= '0;
        end else if (sample == stable) begin
            cnt <= '0;
        end else if (accept) begin
            stable <= sample;
            cnt    <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/magnet_sequencer.sv
// Electromagnet pick/carry/release sequencer with latch retries and a fault latch.
module magnet_sequencer
    import magnet_pkg::*;
#(
    parameter int LATCH_TIMEOUT  = DEF_LATCH_TIMEOUT,
    parameter int RELEASE_CYCLES = DEF_RELEASE_CYCLES,
    parameter int DEBOUNCE       = DEF_DEBOUNCE,
    parameter int MAX_RETRY      = DEF_MAX_RETRY
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       node_valid,
    input  logic [4:0] node,
    input  logic       obj_near,
    input  logic       delatch,
    input  logic       fault_clr,
    output logic       o1,
    output logic       o2,
    output logic       hold,
    output logic       carrying,
    output logic       done,
    output logic       lost,
    output logic       fault
);

    localparam int TMAX = (LATCH_TIMEOUT > RELEASE_CYCLES) ? LATCH_TIMEOUT : RELEASE_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int RW   = $clog2(MAX_RETRY + 1);

    localparam logic [TW-1:0] LATCH_LAST = TW'(LATCH_TIMEOUT - 1);
    localparam logic [TW-1:0] REL_LAST   = TW'(RELEASE_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);

    state_t        state, state_nxt;
    logic [TW-1:0] timer;
    logic [RW-1:0] retry_cnt, retry_nxt;
    logic          obj_filt;
    logic          done_nxt, lost_nxt;
    drive_t        drv;

    presence_filter #(.DEBOUNCE(DEBOUNCE)) u_filter (
        .clk      (clk),
        .rst      (rst),
        .sample   (obj_near),
        .filtered (obj_filt)
    );

    // delatch outranks sensing and timeout in every state where it is honoured.
    always_comb begin
        state_nxt = state;
        retry_nxt = retry_cnt;
        done_nxt  = 1'b0;
        lost_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (node_valid && is_pick_node(node)) begin
                    state_nxt = ST_ENERGIZE;
                    retry_nxt = '0;
                end
            end
            ST_ENERGIZE: begin
                if (delatch) begin
                    state_nxt = ST_RELEASE;
                end else if (obj_filt) begin
                    state_nxt = ST_CARRY;
                end else if (timer == LATCH_LAST) begin
                    retry_nxt = (retry_cnt == RETRY_MAX) ? retry_cnt : retry_cnt + RW'(1);
                    state_nxt = (retry_nxt == RETRY_MAX) ? ST_FAULT : ST_RETRY_GAP;
                end
            end
            ST_RETRY_GAP: begin
                if (delatch)                state_nxt = ST_RELEASE;
                else if (timer == REL_LAST) state_nxt = ST_ENERGIZE;
            end
            ST_CARRY: begin
                if (delatch) begin
                    state_nxt = ST_RELEASE;
                end else if (!obj_filt) begin
                    state_nxt = ST_IDLE;
                    lost_nxt  = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (timer == REL_LAST) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            ST_FAULT: begin
                if (fault_clr) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            timer     <= '0;
            retry_cnt <= '0;
            drv       <= '0;
            done      <= 1'b0;
            lost      <= 1'b0;
        end else begin
            state     <= state_nxt;
            retry_cnt <= retry_nxt;
            // Timer runs only in timed states and restarts on every state change.
            if ((state_nxt != state) || !is_timed(state)) timer <= '0;
            else                                          timer <= timer + TW'(1);
            drv  <= state_drive(state_nxt);
            done <= done_nxt;
            lost <= lost_nxt;
        end
    end

    assign o1       = drv.o1;
    assign o2       = drv.o2;
    assign hold     = drv.hold;
    assign carrying = drv.carrying;
    assign fault    = drv.fault;

endmodule

// File: tb/tb_magnet_sequencer.sv
// Directed bench for magnet_sequencer at default parameters.
module tb_magnet_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       node_valid;
    logic [4:0] node;
    logic       obj_near;
    logic       delatch;
    logic       fault_clr;
    logic       o1, o2, hold, carrying, done, lost, fault;

    int checks    = 0;
    int errors    = 0;
    int overlap   = 0;
    int lost_seen = 0;
    int done_seen = 0;

    // Output vector order: {o1, o2, hold, carrying, done, lost, fault}
    localparam logic [6:0] S_IDLE  = 7'b0000000;
    localparam logic [6:0] S_EN    = 7'b1010000;
    localparam logic [6:0] S_GAP   = 7'b0010000;
    localparam logic [6:0] S_CARRY = 7'b1001000;
    localparam logic [6:0] S_REL   = 7'b0110000;
    localparam logic [6:0] S_FAULT = 7'b0010001;
    localparam logic [6:0] S_DONE  = 7'b0000100;
    localparam logic [6:0] S_LOST  = 7'b0000010;

    wire [6:0] outs = {o1, o2, hold, carrying, done, lost, fault};

    magnet_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .node_valid (node_valid),
        .node       (node),
        .obj_near   (obj_near),
        .delatch    (delatch),
        .fault_clr  (fault_clr),
        .o1         (o1),
        .o2         (o2),
        .hold       (hold),
        .carrying   (carrying),
        .done       (done),
        .lost       (lost),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        assert (!(o1 && o2)) else overlap++;
        if (lost) lost_seen++;
        if (done) done_seen++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_node(input logic [4:0] n);
        node       = n;
        node_valid = 1'b1;
        tick(1);
        node_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; node_valid = 1'b0; node = '0;
        obj_near = 1'b0; delatch = 1'b0; fault_clr = 1'b0;
        tick(2);
        check("reset_outs", outs, S_IDLE);

        // Pick at node 22, accepted on the first cycle out of reset.
        rst = 1'b0;
        pulse_node(5'd22);
        check("energize_first_cycle", outs, S_EN);
        tick(9);
        check("energize_before_obj", outs, S_EN);
        obj_near = 1'b1;
        tick(3);
        check("debounce_pending", outs, S_EN);
        tick(1);
        check("carry_entered", outs, S_CARRY);

        pulse_node(5'd10);
        check("node_in_carry_ignored", outs, S_CARRY);

        // Three-cycle dropout must be filtered; four cycles is a loss.
        obj_near = 1'b0;
        tick(3);
        obj_near = 1'b1;
        tick(1);
        check("glitch3_still_carry", outs, S_CARRY);
        tick(4);
        check("glitch3_no_lost", lost_seen, 0);
        obj_near = 1'b0;
        tick(3);
        check("loss_pending", outs, S_CARRY);
        tick(1);
        check("lost_pulse", outs, S_LOST);
        tick(1);
        check("idle_after_lost", outs, S_IDLE);
        check("lost_count", lost_seen, 1);

        pulse_node(5'd5);
        check("node5_ignored", outs, S_IDLE);
        delatch = 1'b1;
        tick(1);
        delatch = 1'b0;
        check("delatch_idle_ignored", outs, S_IDLE);

        // Full release: o2 for exactly 500 cycles, then one done pulse.
        pulse_node(5'd23);
        obj_near = 1'b1;
        tick(4);
        check("carry_again", outs, S_CARRY);
        delatch = 1'b1;
        tick(1);
        delatch = 1'b0;
        check("release_entered", outs, S_REL);
        tick(499);
        check("release_last_cycle", outs, S_REL);
        tick(1);
        check("done_pulse", outs, S_DONE);
        tick(1);
        check("idle_after_done", outs, S_IDLE);
        check("done_count", done_seen, 1);

        // Object already present: latch on the next cycle; delatch beats a same-cycle loss.
        pulse_node(5'd10);
        tick(1);
        check("carry_fast_relatch", outs, S_CARRY);
        obj_near = 1'b0;
        tick(3);
        delatch = 1'b1;
        tick(1);
        delatch = 1'b0;
        check("delatch_beats_loss", outs, S_REL);
        check("no_lost_on_delatch", lost_seen, 1);

        // Reset 200 cycles into RELEASE.
        tick(199);
        check("release_before_reset", outs, S_REL);
        rst = 1'b1;
        tick(1);
        check("reset_mid_release", outs, S_IDLE);
        rst = 1'b0;
        tick(1);
        check("idle_after_reset", outs, S_IDLE);

        // No object: three energise windows, two gaps, then FAULT.
        pulse_node(5'd11);
        for (int w = 0; w < 3; w++) begin
            check("energize_window_start", outs, S_EN);
            tick(999);
            check("energize_window_end", outs, S_EN);
            tick(1);
            if (w < 2) begin
                check("gap_start", outs, S_GAP);
                tick(499);
                check("gap_end", outs, S_GAP);
                tick(1);
            end
        end
        check("fault_entered", outs, S_FAULT);
        delatch = 1'b1;
        pulse_node(5'd22);
        delatch = 1'b0;
        check("fault_ignores_inputs", outs, S_FAULT);
        fault_clr = 1'b1;
        tick(1);
        fault_clr = 1'b0;
        check("fault_clr_idle", outs, S_IDLE);

        // Abort from ENERGIZE, delatch outranking a present object.
        obj_near = 1'b1;
        pulse_node(5'd10);
        delatch = 1'b1;
        tick(1);
        delatch = 1'b0;
        obj_near = 1'b0;
        check("delatch_aborts_energize", outs, S_REL);
        tick(500);
        check("abort_done", outs, S_DONE);

        // Abort from RETRY_GAP.
        pulse_node(5'd22);
        tick(1000);
        check("gap_after_timeout", outs, S_GAP);
        delatch = 1'b1;
        tick(1);
        delatch = 1'b0;
        check("delatch_aborts_gap", outs, S_REL);
        tick(500);
        check("gap_abort_done", outs, S_DONE);
        tick(1);
        check("done_total", done_seen, 3);
        check("o1_o2_overlap", overlap, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
